// File: rtl/wb_reg_master.sv
// -----------------------------------------------------------------------------
// wb_reg_master
//
// Single-word register master for a pipelined-mode Wishbone bus. A local
// controller hands over one read or write at a time. The master strobes it
// onto the bus, waits for the slave to terminate it, re-issues it on retry,
// aborts it on timeout, and returns a one-cycle response pulse.
//
// Parameters
//   TIMEOUT    : cycles allowed from first strobe to termination (2..255)
//   MAX_RETRY  : re-issues allowed on wb_rty_i before reporting error (0..7)
//   ADDR_WIDTH : width of request and bus word address
//
// Ports
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   req_i / req_ready_o   : request handshake (accepted when both high)
//   req_we_i, req_adr_i,
//   req_dat_i             : request direction, word address, write data
//   rsp_valid_o           : one-cycle pulse when a transaction finishes
//   rsp_dat_o             : last read data (held until the next read completes)
//   rsp_err_o             : bus error, retries exhausted or timeout
//   rsp_timeout_o         : error was caused by timeout
//   wb_cyc_o, wb_stb_o,
//   wb_we_o, wb_sel_o,
//   wb_adr_o, wb_dat_o    : registered Wishbone master outputs
//   wb_ack_i, wb_err_i,
//   wb_rty_i, wb_stall_i,
//   wb_dat_i              : Wishbone slave responses
// -----------------------------------------------------------------------------
module wb_reg_master #(
  parameter int TIMEOUT    = 16,
  parameter int MAX_RETRY  = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  // local request side
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_adr_i,
  input  logic [31:0]           req_dat_i,
  output logic                  req_ready_o,
  // local response side
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  // Wishbone master
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  // S_RTRY is the single bus-released cycle between a retry and the re-issue.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_WAIT   = 3'd2,
    S_RTRY   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  // Counter value during the last allowed cycle of an attempt.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] RTY_MAX  = 3'(MAX_RETRY);

  state_e                  state_q, state_d;
  logic [7:0]              tmo_q, tmo_d;
  logic [2:0]              rty_q, rty_d;

  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [3:0]              sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [31:0]             wdat_q, wdat_d;

  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_to_q, rsp_to_d;
  logic [31:0]             rsp_dat_q, rsp_dat_d;

  logic                    term_ok;
  logic                    tmo_hit;

  // A slave termination only counts once the strobe has been taken
  // (stall low) or while waiting; anything seen in IDLE/RTRY/RESP is ignored.
  assign term_ok = (state_q == S_WAIT) || ((state_q == S_STROBE) && !wb_stall_i);
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    rty_d       = rty_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    rsp_dat_d   = rsp_dat_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d   = S_STROBE;
          we_d      = req_we_i;
          adr_d     = req_adr_i;
          wdat_d    = req_dat_i;
          tmo_d     = 8'd0;
          rty_d     = 3'd0;
          rsp_err_d = 1'b0;
          rsp_to_d  = 1'b0;
        end
      end

      S_STROBE, S_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        // Priority: err > ack > rty > timeout.
        if (term_ok && wb_err_i) begin
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else if (term_ok && wb_ack_i) begin
          if (!we_q) begin
            rsp_dat_d = wb_dat_i;
          end
          state_d = S_RESP;
        end else if (term_ok && wb_rty_i) begin
          if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + 3'd1;
            tmo_d   = 8'd0;
            state_d = S_RTRY;
          end else begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end
        end else if (tmo_hit) begin
          rsp_err_d = 1'b1;
          rsp_to_d  = 1'b1;
          state_d   = S_RESP;
        end else if ((state_q == S_STROBE) && !wb_stall_i) begin
          state_d = S_WAIT;
        end
      end

      S_RTRY: begin
        tmo_d   = 8'd0;
        state_d = S_STROBE;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus and response outputs are registered from the next state so they
    // line up exactly with the state they describe.
    cyc_d       = (state_d == S_STROBE) || (state_d == S_WAIT);
    stb_d       = (state_d == S_STROBE);
    sel_d       = stb_d ? 4'hF : 4'h0;
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      tmo_q       <= 8'd0;
      rty_q       <= 3'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= '0;
      wdat_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_dat_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      rty_q       <= rty_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = stb_q;
  assign wb_we_o       = we_q;
  assign wb_sel_o      = sel_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = wdat_q;

endmodule

// File: tb/tb_wb_reg_master.sv
// -----------------------------------------------------------------------------
// tb_wb_reg_master
//
// Self-checking bench for wb_reg_master. The slave is described per attempt
// by a plan: stall cycles s, response delay d after the stall drops, and a
// response kind. A reference model derives the expected outcome, latency,
// strobe/cycle counts and read data directly from those numbers.
// -----------------------------------------------------------------------------
module tb_wb_reg_master;

  localparam int TMO  = 16;
  localparam int MAXR = 3;
  localparam int AW   = 8;
  localparam int LIMIT = 400;

  // response kinds
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_RTY  = 2;
  localparam int K_NONE = 3;
  localparam int K_BOTH = 4;
  localparam int K_TMO  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_i = 1'b0;
  logic          req_we_i = 1'b0;
  logic [AW-1:0] req_adr_i = '0;
  logic [31:0]   req_dat_i = '0;
  logic          req_ready_o;
  logic          rsp_valid_o;
  logic [31:0]   rsp_dat_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;
  logic          wb_rty_i = 1'b0;
  logic          wb_stall_i = 1'b0;
  logic [31:0]   wb_dat_i = '0;

  int checks = 0;
  int errors = 0;

  // slave plan, one entry per attempt
  int ps [8];
  int pd [8];
  int pk [8];

  // model results
  int          e_cyc, e_att, e_stb, e_cycc;
  logic        e_err, e_to;
  logic [31:0] e_dat;
  logic [31:0] model_rd;

  // observations
  int          o_rsp, o_att, o_stb, o_cycc, o_bad;
  logic        o_err, o_to, o_ready, o_valid;
  logic [31:0] o_dat;

  wb_reg_master #(.TIMEOUT(TMO), .MAX_RETRY(MAXR), .ADDR_WIDTH(AW)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_i         (req_i),
    .req_we_i      (req_we_i),
    .req_adr_i     (req_adr_i),
    .req_dat_i     (req_dat_i),
    .req_ready_o   (req_ready_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_sel_o      (wb_sel_o),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i),
    .wb_rty_i      (wb_rty_i),
    .wb_stall_i    (wb_stall_i),
    .wb_dat_i      (wb_dat_i)
  );

  always #5 clk = ~clk;

  task automatic fill_plan(input int s, input int d, input int k);
    for (int i = 0; i < 8; i++) begin
      ps[i] = s; pd[i] = d; pk[i] = k;
    end
  endtask

  // Reference model: cycle 0 is the accept, first strobe at cycle 1.
  // An attempt ends at local cycle s+d if the slave answers before the
  // timeout budget runs out, otherwise at local cycle TMO-1.
  task automatic model_txn(input logic we, input logic [31:0] rdata);
    int r, cyc, kend, out;
    cyc = 1; r = 0; out = K_NONE;
    e_att = 0; e_stb = 0; e_cycc = 0;
    for (int i = 0; i < 8; i++) begin
      e_att++;
      if (pk[i] != K_NONE && ps[i] + pd[i] < TMO) begin
        kend = ps[i] + pd[i]; out = pk[i];
      end else begin
        kend = TMO - 1; out = K_TMO;
      end
      e_stb  += (ps[i] + 1 < TMO) ? ps[i] + 1 : TMO;
      e_cycc += kend + 1;
      cyc    += kend + 1;
      if (out == K_RTY && r < MAXR) begin
        r++;
        cyc++;
      end else begin
        break;
      end
    end
    e_cyc = cyc;
    e_err = (out != K_ACK);
    e_to  = (out == K_TMO);
    if (!we && out == K_ACK) model_rd = rdata;
    e_dat = model_rd;
  endtask

  // Drives one transaction from an idle cycle (posedge+1) and records what
  // the DUT did; returns at posedge+1 of the cycle after the response.
  task automatic run_txn(input logic we, input logic [AW-1:0] adr,
                         input logic [31:0] dat, input logic [31:0] rdata,
                         input logic noise);
    int n, k, att;
    logic prev_cyc, done;
    o_rsp = -1; o_att = 0; o_stb = 0; o_cycc = 0; o_bad = 0;
    o_err = 1'b0; o_to = 1'b0; o_dat = '0; o_ready = 1'b0; o_valid = 1'b1;
    req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat;
    wb_dat_i = rdata;
    @(posedge clk); #1;
    n = 1; k = 0; att = 0; prev_cyc = 1'b0; done = 1'b0;
    while (!done && n <= LIMIT) begin
      if (noise) begin
        req_i = 1'b1; req_we_i = $urandom_range(0, 1);
        req_adr_i = AW'($urandom); req_dat_i = $urandom;
      end else begin
        req_i = 1'b0;
      end
      if (wb_cyc_o) begin
        if (!prev_cyc) begin att++; k = 0; end
        else k++;
        o_cycc++;
      end
      if (wb_stb_o) begin
        o_stb++;
        if (wb_we_o !== we || wb_adr_o !== adr || wb_dat_o !== dat || wb_sel_o !== 4'hF)
          o_bad++;
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
      if (rsp_valid_o) begin
        o_rsp = n; o_err = rsp_err_o; o_to = rsp_timeout_o; o_dat = rsp_dat_o;
        req_i = 1'b0;
        done = 1'b1;
      end else if (wb_cyc_o && att >= 1 && att <= 8) begin
        wb_stall_i = (k < ps[att-1]);
        if (k == ps[att-1] + pd[att-1]) begin
          wb_ack_i = (pk[att-1] == K_ACK) || (pk[att-1] == K_BOTH);
          wb_err_i = (pk[att-1] == K_ERR) || (pk[att-1] == K_BOTH);
          wb_rty_i = (pk[att-1] == K_RTY);
        end
      end
      prev_cyc = wb_cyc_o;
      if (!done) begin
        @(posedge clk); #1;
        n++;
      end
    end
    o_att = att;
    req_i = 1'b0;
    @(posedge clk); #1;
    o_ready = req_ready_o;
    o_valid = rsp_valid_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: cyc/stb/we=%b%b%b want 000", wb_cyc_o, wb_stb_o, wb_we_o); end
    checks++; if (wb_sel_o !== 4'h0 || wb_adr_o !== '0 || wb_dat_o !== 32'd0) begin
      errors++; $display("FAIL reset_bus: sel=%h adr=%h dat=%h want 0", wb_sel_o, wb_adr_o, wb_dat_o); end
    checks++; if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_timeout_o !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: v/e/t=%b%b%b want 000", rsp_valid_o, rsp_err_o, rsp_timeout_o); end
    checks++; if (rsp_dat_o !== 32'd0) begin
      errors++; $display("FAIL reset_rdat: got %h want 0", rsp_dat_o); end
    checks++; if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
    model_rd = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ignore();
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1;
    @(posedge clk); #1;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b0 || wb_cyc_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL idle_ignore: valid=%b cyc=%b ready=%b want 0 0 1", rsp_valid_o, wb_cyc_o, req_ready_o); end
  endtask

  task automatic test_write_basic();
    fill_plan(0, 1, K_ACK);
    model_txn(1'b1, 32'h0);
    run_txn(1'b1, 8'h21, 32'hDEADBEEF, 32'h0, 1'b0);
    checks++; if (o_rsp != 3 || o_rsp != e_cyc) begin
      errors++; $display("FAIL wr_latency: got %0d want 3", o_rsp); end
    checks++; if (o_stb != 1 || o_bad != 0) begin
      errors++; $display("FAIL wr_strobe: stb cycles %0d bad %0d want 1 0", o_stb, o_bad); end
    checks++; if (o_err !== 1'b0 || o_dat !== e_dat) begin
      errors++; $display("FAIL wr_rsp: err=%b dat=%h want 0 %h", o_err, o_dat, e_dat); end
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL wr_pulse: ready=%b valid=%b want 1 0", o_ready, o_valid); end
  endtask

  task automatic test_read_stall();
    fill_plan(3, 1, K_ACK);
    model_txn(1'b0, 32'h12345678);
    run_txn(1'b0, 8'h40, 32'h0, 32'h12345678, 1'b0);
    checks++; if (o_stb != 4) begin
      errors++; $display("FAIL rd_stall_stb: got %0d want 4", o_stb); end
    checks++; if (o_dat !== 32'h12345678 || o_err !== 1'b0) begin
      errors++; $display("FAIL rd_stall_data: got %h err %b want 12345678 0", o_dat, o_err); end
    checks++; if (o_rsp != e_cyc) begin
      errors++; $display("FAIL rd_stall_latency: got %0d want %0d", o_rsp, e_cyc); end
  endtask

  task automatic test_retry();
    fill_plan(0, 1, K_RTY);
    model_txn(1'b0, 32'hAAAA5555);
    run_txn(1'b0, 8'h07, 32'h0, 32'hAAAA5555, 1'b0);
    checks++; if (o_att != 4 || o_att != e_att) begin
      errors++; $display("FAIL retry_attempts: got %0d want 4", o_att); end
    checks++; if (o_err !== 1'b1 || o_to !== 1'b0) begin
      errors++; $display("FAIL retry_rsp: err=%b to=%b want 1 0", o_err, o_to); end
    checks++; if (o_rsp != e_cyc || o_dat !== e_dat) begin
      errors++; $display("FAIL retry_latency: got %0d dat %h want %0d %h", o_rsp, o_dat, e_cyc, e_dat); end
  endtask

  task automatic test_timeout();
    fill_plan(0, 0, K_NONE);
    model_txn(1'b0, 32'h0BADF00D);
    run_txn(1'b0, 8'h99, 32'h0, 32'h0BADF00D, 1'b0);
    checks++; if (o_cycc != 16) begin
      errors++; $display("FAIL timeout_cyc: cyc high %0d want 16", o_cycc); end
    checks++; if (o_err !== 1'b1 || o_to !== 1'b1) begin
      errors++; $display("FAIL timeout_rsp: err=%b to=%b want 1 1", o_err, o_to); end
    checks++; if (o_rsp != 17 || o_dat !== e_dat) begin
      errors++; $display("FAIL timeout_latency: got %0d dat %h want 17 %h", o_rsp, o_dat, e_dat); end
  endtask

  task automatic test_ack_err();
    fill_plan(1, 2, K_BOTH);
    model_txn(1'b0, 32'hFEEDFACE);
    run_txn(1'b0, 8'h33, 32'h0, 32'hFEEDFACE, 1'b0);
    checks++; if (o_err !== 1'b1 || o_to !== 1'b0) begin
      errors++; $display("FAIL ackerr_rsp: err=%b to=%b want 1 0", o_err, o_to); end
    checks++; if (o_dat !== e_dat) begin
      errors++; $display("FAIL ackerr_data: got %h want %h", o_dat, e_dat); end
  endtask

  task automatic test_back_to_back();
    fill_plan(0, 0, K_ACK);
    model_txn(1'b1, 32'h0);
    run_txn(1'b1, 8'h01, 32'h01020304, 32'h0, 1'b1);
    checks++; if (o_rsp != e_cyc || o_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: rsp %0d ready %b want %0d 1", o_rsp, o_ready, e_cyc); end
    model_txn(1'b0, 32'h55667788);
    run_txn(1'b0, 8'h02, 32'h0, 32'h55667788, 1'b1);
    checks++; if (o_rsp != e_cyc || o_dat !== e_dat || o_bad != 0) begin
      errors++; $display("FAIL b2b_second: rsp %0d dat %h bad %0d want %0d %h 0", o_rsp, o_dat, o_bad, e_cyc, e_dat); end
  endtask

  task automatic test_random();
    logic we;
    logic [AW-1:0] adr;
    logic [31:0] dat, rdata;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 8; i++) begin
        ps[i] = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(0, 3);
        pd[i] = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
        pk[i] = $urandom_range(0, 4);
      end
      we = $urandom_range(0, 1); adr = AW'($urandom); dat = $urandom; rdata = $urandom;
      model_txn(we, rdata);
      run_txn(we, adr, dat, rdata, $urandom_range(0, 1) == 1);
      checks++; if (o_rsp != e_cyc) begin
        errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, o_rsp, e_cyc); end
      checks++; if (o_err !== e_err || o_to !== e_to) begin
        errors++; $display("FAIL rnd%0d_status: err/to=%b%b want %b%b", t, o_err, o_to, e_err, e_to); end
      checks++; if (o_dat !== e_dat) begin
        errors++; $display("FAIL rnd%0d_data: got %h want %h", t, o_dat, e_dat); end
      checks++; if (o_att != e_att || o_stb != e_stb || o_cycc != e_cycc) begin
        errors++; $display("FAIL rnd%0d_bus: att/stb/cyc=%0d/%0d/%0d want %0d/%0d/%0d",
                           t, o_att, o_stb, o_cycc, e_att, e_stb, e_cycc); end
      checks++; if (o_bad != 0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_ctl: bad=%0d ready=%b valid=%b want 0 1 0", t, o_bad, o_ready, o_valid); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 8'h5A;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_wait: cyc=%b stb=%b want 1 0", wb_cyc_o, wb_stb_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_dat_o !== 32'd0) begin
      errors++; $display("FAIL rstmid_async: cyc=%b ready=%b rdat=%h want 0 1 0", wb_cyc_o, req_ready_o, rsp_dat_o); end
    model_rd = 32'd0;
    seen = 0;
    @(posedge clk); #1;
    if (rsp_valid_o) seen++;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid_o || wb_cyc_o) seen++;
    end
    checks++; if (seen != 0) begin
      errors++; $display("FAIL rstmid_nopulse: activity cycles %0d want 0", seen); end
    fill_plan(0, 1, K_ACK);
    model_txn(1'b0, 32'hC0FFEE00);
    run_txn(1'b0, 8'h10, 32'h0, 32'hC0FFEE00, 1'b0);
    checks++; if (o_rsp != e_cyc || o_dat !== e_dat || o_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_recover: rsp %0d dat %h err %b want %0d %h 0", o_rsp, o_dat, o_err, e_cyc, e_dat); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_write_basic();
    test_read_stall();
    test_retry();
    test_timeout();
    test_ack_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
